mvm_stream_ctrl: RTL and testbench
==================================

Name: mvm_stream_ctrl

Overview:
- Input sequencer in front of the KERNEL_SIZE x KERNEL_SIZE matrix-vector MAC array.
- Receives the single 32-bit AXI-Stream input and splits it into two phases: weight loading, then data-row streaming.
- Packs bus beats into full weight rows and data rows, and issues them to the array.
- Limits in-flight rows with a credit counter that tracks result retirement on the output stream.

Parameters:
- KERNEL_SIZE, 16, PEs per array, and elements per row.
- DATA_WIDTH, 8, width of one data element.
- WEIGHT_WIDTH, 8, width of one weight.
- BUS_WIDTH, 32, s_axis_tdata width. KERNEL_SIZE*DATA_WIDTH and KERNEL_SIZE*WEIGHT_WIDTH must both be multiples of BUS_WIDTH.
- MAX_INFLIGHT, 4, maximum number of issued rows without a retired result. Equals the array output FIFO DEPTH.

Ports:
- clk  in  1  Single clock.
- rstn  in  1  Reset, asynchronous, active-low.
- s_axis_tdata  in  BUS_WIDTH  Input beat. Beat n of a row lands at bits [n*BUS_WIDTH +: BUS_WIDTH], first beat lowest.
- s_axis_tvalid  in  1  Input beat valid.
- s_axis_tready  out  1  Input beat accept.
- cfg_reload  in  1  One-cycle pulse requesting a new weight load.
- wt_we  out  1  Weight-row write strobe, one cycle.
- wt_addr  out  clog2(KERNEL_SIZE)  PE index of the weight row.
- wt_data  out  KERNEL_SIZE*WEIGHT_WIDTH  Weight row. Byte k is weight[wt_addr*KERNEL_SIZE+k].
- row_valid  out  1  Data row valid.
- row_ready  in  1  Array accepts the data row.
- row_data  out  KERNEL_SIZE*DATA_WIDTH  Data row, element k at [k*DATA_WIDTH +: DATA_WIDTH].
- res_fire  in  1  Asserted when m_axis_tvalid and m_axis_tready are both high on the array output.
- weights_loaded  out  1  All KERNEL_SIZE weight rows are written.
- inflight  out  clog2(MAX_INFLIGHT+1)  Current number of issued but unretired rows.
- err_underflow  out  1  Sticky error flag.

Behaviour:
- Reset values: state=LOAD_W; all counters 0; s_axis_tready, wt_we, wt_addr, wt_data, row_valid, row_data, weights_loaded, inflight, err_underflow all 0.
- Derived constants:
  - WBEATS = KERNEL_SIZE*WEIGHT_WIDTH/BUS_WIDTH (4 at default).
  - DBEATS = KERNEL_SIZE*DATA_WIDTH/BUS_WIDTH (4 at default).
  - A full weight load is KERNEL_SIZE*WBEATS beats (64 at default).
- A beat is accepted when s_axis_tvalid and s_axis_tready are both high. s_axis_tready is combinational from registered state and is forced 0 in any cycle where cfg_reload=1.
- State LOAD_W:
  - tready=1 (except in a cfg_reload cycle).
  - Beats are packed into the weight buffer.
  - When beat WBEATS-1 of row r is accepted in cycle t: wt_we=1 in t+1 with wt_addr=r and the packed row.
  - When the last beat of row KERNEL_SIZE-1 is accepted in cycle t: state=STREAM and weights_loaded=1 in t+1.
  - cfg_reload in LOAD_W: beat and row counters clear, any partial row is discarded, state is unchanged.
- State STREAM:
  - tready = !row_valid && (inflight < MAX_INFLIGHT).
  - When beat DBEATS-1 is accepted in cycle t: row_valid=1 in t+1.
  - row_valid and row_data are held stable until row_ready. On row_valid && row_ready, row_valid drops next cycle.
  - cfg_reload in STREAM: the partial row is discarded, and state goes to DRAIN next cycle.
- State DRAIN:
  - tready=0.
  - A pending row_valid is still held until accepted.
  - Exits to LOAD_W when !row_valid && inflight==0. weights_loaded clears on that transition.
  - cfg_reload in DRAIN is ignored.
- Credit counter updates each cycle:
  - +1 on row issue (row_valid && row_ready).
  - -1 on res_fire.
  - Both in the same cycle: unchanged.
  - res_fire while inflight==0: counter stays 0 and err_underflow is set. It clears only on reset.
  - Issue never occurs at inflight==MAX_INFLIGHT, because tready gates beat acceptance.
- Asynchronous reset mid-operation: everything returns to reset values immediately, partial rows are lost, and a full weight reload is required.

Decomposition:
- Package mvm_pkg holds the state enum (LOAD_W, STREAM, DRAIN) and the functions for WBEATS, DBEATS and counter widths.
- Sub-module beat_packer: parameterised by BEATS and BUS_WIDTH. Takes an accept strobe and a clear, outputs the packed word and a last-beat flag. It is instantiated twice, once for weights and once for data.

Test Plan:
- Reset release, then weights 0..255 sent as 64 beats (beat i = {w[4i+3],w[4i+2],w[4i+1],w[4i]}) -> 16 wt_we pulses, wt_addr 0..15, row 1 wt_data bytes 16..31; weights_loaded=1 the cycle after beat 64.
- Stream row j=0 (elements 0..15) with row_ready=1 -> row_valid one cycle after 4th beat, row_data bytes 0..15, inflight=1.
- 5 rows with res_fire held 0 -> 4 rows issue, tready=0 with inflight=4; one res_fire -> inflight=3 and the 5th row proceeds.
- row_ready low for 10 cycles with row_valid=1 -> row_data stable, tready=0; simultaneous issue and res_fire at inflight=2 -> stays 2.
- cfg_reload after 2 beats of a data row with inflight=3 -> partial discarded, DRAIN, tready=0 until 3 res_fire, then LOAD_W with weights_loaded=0 and a new 64-beat load accepted.
- res_fire at inflight=0 -> err_underflow=1, sticky; rstn pulsed low mid-weight-load -> all outputs 0 immediately.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the MVM input sequencer.
// Imported by the stream controller and its beat packer.
package mvm_pkg;

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  function automatic int row_beats(
    input int elems,
    input int elem_w,
    input int bus_w
  );
    return (elems * elem_w) / bus_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/beat_packer.sv
// Packs consecutive bus beats into one wide row, first beat lowest.
// word_o already contains the beat being accepted this cycle.
module beat_packer
  import mvm_pkg::*;
#(
  parameter int BEATS     = 4,
  parameter int BUS_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       acc_i,
  input  logic                       clr_i,
  input  logic [BUS_WIDTH-1:0]       din_i,
  output logic [BEATS*BUS_WIDTH-1:0] word_o,
  output logic                       last_o
);

  localparam int CW = cnt_w(BEATS);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [BEATS*BUS_WIDTH-1:0] pk_q, pk_d;

  assign last_o = (cnt_q == CW'(BEATS - 1));
  assign word_o = pk_d;

  always_comb begin
    cnt_d = cnt_q;
    pk_d  = pk_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (acc_i) begin
      pk_d[cnt_q*BUS_WIDTH +: BUS_WIDTH] = din_i;
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      pk_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      pk_q  <= pk_d;
    end
  end

endmodule

// File: rtl/mvm_stream_ctrl.sv
// Input sequencer for the MVM array: weight load, then credit-limited
// data-row streaming, with a drain phase before any weight reload.
module mvm_stream_ctrl
  import mvm_pkg::*;
#(
  parameter int KERNEL_SIZE  = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BUS_WIDTH    = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [BUS_WIDTH-1:0]                 s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 cfg_reload,
  output logic                                 wt_we,
  output logic [$clog2(KERNEL_SIZE)-1:0]       wt_addr,
  output logic [KERNEL_SIZE*WEIGHT_WIDTH-1:0]  wt_data,
  output logic                                 row_valid,
  input  logic                                 row_ready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0]    row_data,
  input  logic                                 res_fire,
  output logic                                 weights_loaded,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic                                 err_underflow
);

  localparam int WBEATS = row_beats(KERNEL_SIZE, WEIGHT_WIDTH, BUS_WIDTH);
  localparam int DBEATS = row_beats(KERNEL_SIZE, DATA_WIDTH, BUS_WIDTH);
  localparam int AW     = $clog2(KERNEL_SIZE);
  localparam int IW     = $clog2(MAX_INFLIGHT + 1);
  localparam int WROW   = KERNEL_SIZE * WEIGHT_WIDTH;
  localparam int DROW   = KERNEL_SIZE * DATA_WIDTH;

  state_e          state_q, state_d;
  logic            run_q;
  logic [AW-1:0]   wrow_q, wrow_d;
  logic            wt_we_q, wt_we_d;
  logic [AW-1:0]   wt_addr_q, wt_addr_d;
  logic [WROW-1:0] wt_data_q, wt_data_d;
  logic            row_valid_q, row_valid_d;
  logic [DROW-1:0] row_data_q, row_data_d;
  logic            loaded_q, loaded_d;
  logic [IW-1:0]   infl_q, infl_d;
  logic            err_q, err_d;

  logic            rdy;
  logic            acc;
  logic            w_acc, w_clr, w_last;
  logic            d_acc, d_clr, d_last;
  logic            issue;
  logic [WROW-1:0] w_word;
  logic [DROW-1:0] d_word;

  // run_q keeps tready low while and right after reset is applied
  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      LOAD_W:  rdy = 1'b1;
      STREAM:  rdy = !row_valid_q && (infl_q < IW'(MAX_INFLIGHT));
      default: rdy = 1'b0;
    endcase
    if (cfg_reload || !run_q) rdy = 1'b0;
  end

  assign acc   = s_axis_tvalid && rdy;
  assign w_acc = acc && (state_q == LOAD_W);
  assign d_acc = acc && (state_q == STREAM);
  assign w_clr = cfg_reload && (state_q == LOAD_W);
  assign d_clr = cfg_reload && (state_q == STREAM);
  assign issue = row_valid_q && row_ready;

  beat_packer #(
    .BEATS     (WBEATS),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_wpack (
    .clk    (clk),
    .rstn   (rstn),
    .acc_i  (w_acc),
    .clr_i  (w_clr),
    .din_i  (s_axis_tdata),
    .word_o (w_word),
    .last_o (w_last)
  );

  beat_packer #(
    .BEATS     (DBEATS),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_dpack (
    .clk    (clk),
    .rstn   (rstn),
    .acc_i  (d_acc),
    .clr_i  (d_clr),
    .din_i  (s_axis_tdata),
    .word_o (d_word),
    .last_o (d_last)
  );

  always_comb begin
    state_d     = state_q;
    wrow_d      = wrow_q;
    wt_we_d     = 1'b0;
    wt_addr_d   = wt_addr_q;
    wt_data_d   = wt_data_q;
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    loaded_d    = loaded_q;
    infl_d      = infl_q;
    err_d       = err_q;

    if (issue) row_valid_d = 1'b0;

    unique case (state_q)
      LOAD_W: begin
        if (cfg_reload) begin
          wrow_d = '0;
        end else if (w_acc && w_last) begin
          wt_we_d   = 1'b1;
          wt_addr_d = wrow_q;
          wt_data_d = w_word;
          wrow_d    = wrow_q + 1'b1;
          if (wrow_q == AW'(KERNEL_SIZE - 1)) begin
            state_d  = STREAM;
            loaded_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (cfg_reload) begin
          state_d = DRAIN;
        end else if (d_acc && d_last) begin
          row_valid_d = 1'b1;
          row_data_d  = d_word;
        end
      end
      DRAIN: begin
        if (!row_valid_q && (infl_q == '0)) begin
          state_d  = LOAD_W;
          loaded_d = 1'b0;
          wrow_d   = '0;
        end
      end
      default: state_d = LOAD_W;
    endcase

    // simultaneous issue and retire cancel out
    unique case (1'b1)
      issue && !res_fire:
        infl_d = infl_q + 1'b1;
      res_fire && !issue && (infl_q != '0):
        infl_d = infl_q - 1'b1;
      res_fire && !issue && (infl_q == '0):
        err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= LOAD_W;
      run_q       <= 1'b0;
      wrow_q      <= '0;
      wt_we_q     <= 1'b0;
      wt_addr_q   <= '0;
      wt_data_q   <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      loaded_q    <= 1'b0;
      infl_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      wrow_q      <= wrow_d;
      wt_we_q     <= wt_we_d;
      wt_addr_q   <= wt_addr_d;
      wt_data_q   <= wt_data_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      loaded_q    <= loaded_d;
      infl_q      <= infl_d;
      err_q       <= err_d;
    end
  end

  assign s_axis_tready  = rdy;
  assign wt_we          = wt_we_q;
  assign wt_addr        = wt_addr_q;
  assign wt_data        = wt_data_q;
  assign row_valid      = row_valid_q;
  assign row_data       = row_data_q;
  assign weights_loaded = loaded_q;
  assign inflight       = infl_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_mvm_stream_ctrl.sv
// Scoreboard bench for mvm_stream_ctrl: expected weight and data rows are
// queued by the stimulus and popped by a monitor on each DUT output event.
module tb_mvm_stream_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         cfg_reload;
  logic         wt_we;
  logic [3:0]   wt_addr;
  logic [127:0] wt_data;
  logic         row_valid;
  logic         row_ready;
  logic [127:0] row_data;
  logic         res_fire;
  logic         weights_loaded;
  logic [2:0]   inflight;
  logic         err_underflow;

  typedef struct {
    logic [3:0]   a;
    logic [127:0] d;
  } wexp_t;

  wexp_t        wq[$];
  logic [127:0] rq[$];
  int           checks = 0;
  int           errors = 0;

  mvm_stream_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .cfg_reload     (cfg_reload),
    .wt_we          (wt_we),
    .wt_addr        (wt_addr),
    .wt_data        (wt_data),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .row_data       (row_data),
    .res_fire       (res_fire),
    .weights_loaded (weights_loaded),
    .inflight       (inflight),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] wv(input int mode, input int i);
    logic [7:0] r;
    case (mode)
      0:       r = 8'(i);
      1:       r = 8'(255 - i);
      default: r = 8'(i) ^ 8'h5a;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] wbeat(input int mode, input int b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wv(mode, 4*b + k);
    return r;
  endfunction

  function automatic logic [127:0] wrow(input int mode, input int r);
    logic [127:0] x;
    for (int k = 0; k < 16; k++) x[8*k +: 8] = wv(mode, 16*r + k);
    return x;
  endfunction

  function automatic logic [7:0] dv(input int j, input int k);
    return 8'(16*j + k);
  endfunction

  function automatic logic [31:0] dbeat(input int j, input int n);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = dv(j, 4*n + k);
    return r;
  endfunction

  function automatic logic [127:0] drow(input int j);
    logic [127:0] x;
    for (int k = 0; k < 16; k++) x[8*k +: 8] = dv(j, k);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: got timeout expected tready");
    end
  endtask

  task automatic load_w(input int nb, input int mode);
    wexp_t e;
    for (int i = 0; i < nb; i++) begin
      if ((i % 4 == 0) && (i + 4 <= nb)) begin
        e.a = 4'(i / 4);
        e.d = wrow(mode, i / 4);
        wq.push_back(e);
      end
      if (i == 63) chk("loaded_before_last", weights_loaded, 0);
      send_beat(wbeat(mode, i));
    end
  endtask

  task automatic send_row(input int j);
    rq.push_back(drow(j));
    for (int n = 0; n < 4; n++) send_beat(dbeat(j, n));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 0);
    chk({tag, "_wt_we"}, wt_we, 0);
    chk({tag, "_wt_addr"}, wt_addr, 0);
    chk({tag, "_wt_data"}, wt_data, 0);
    chk({tag, "_row_valid"}, row_valid, 0);
    chk({tag, "_row_data"}, row_data, 0);
    chk({tag, "_loaded"}, weights_loaded, 0);
    chk({tag, "_inflight"}, inflight, 0);
    chk({tag, "_err"}, err_underflow, 0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (wt_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wt_unexpected: got addr %0h expected none", wt_addr);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("wt_addr", wt_addr, e.a);
          chk("wt_data", wt_data, e.d);
        end
      end
      if (row_valid && row_ready) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL row_unexpected: got %0h expected none", row_data);
        end else begin
          chk("row_data", row_data, rq.pop_front());
        end
      end
    end
  end

  initial begin
    rstn          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    cfg_reload    = 1'b0;
    row_ready     = 1'b0;
    res_fire      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    chk("tready_load", s_axis_tready, 1);

    load_w(64, 0);
    chk("loaded_after_load", weights_loaded, 1);
    tick();
    tick();
    chk("wt_queue_drained", wq.size(), 0);

    row_ready = 1'b1;
    send_row(0);
    chk("row0_valid", row_valid, 1);
    chk("row0_inflight_pre", inflight, 0);
    tick();
    chk("row0_inflight", inflight, 1);
    chk("row0_valid_drop", row_valid, 0);

    send_row(1);
    send_row(2);
    send_row(3);
    tick();
    chk("full_inflight", inflight, 4);
    s_axis_tdata  = dbeat(4, 0);
    s_axis_tvalid = 1'b1;
    tick();
    chk("full_tready", s_axis_tready, 0);
    res_fire = 1'b1;
    tick();
    res_fire = 1'b0;
    chk("retire_inflight", inflight, 3);
    s_axis_tvalid = 1'b0;
    send_row(4);
    tick();
    chk("row4_inflight", inflight, 4);

    res_fire = 1'b1;
    tick();
    tick();
    res_fire = 1'b0;
    chk("two_retire", inflight, 2);

    row_ready = 1'b0;
    send_row(5);
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", row_valid, 1);
      chk("stall_data", row_data, drow(5));
      chk("stall_tready", s_axis_tready, 0);
      tick();
    end
    row_ready = 1'b1;
    res_fire  = 1'b1;
    tick();
    res_fire = 1'b0;
    chk("issue_and_retire", inflight, 2);
    chk("stall_release", row_valid, 0);

    send_row(6);
    tick();
    chk("pre_reload_inflight", inflight, 3);
    send_beat(dbeat(7, 0));
    send_beat(dbeat(7, 1));
    s_axis_tdata  = dbeat(7, 2);
    s_axis_tvalid = 1'b1;
    cfg_reload    = 1'b1;
    @(negedge clk);
    chk("reload_tready", s_axis_tready, 0);
    tick();
    cfg_reload = 1'b0;
    chk("drain_tready", s_axis_tready, 0);
    chk("drain_loaded", weights_loaded, 1);
    for (int i = 0; i < 3; i++) begin
      res_fire = 1'b1;
      tick();
      res_fire = 1'b0;
      chk("drain_inflight", inflight, 3'(2 - i));
      chk("drain_tready_hold", s_axis_tready, 0);
    end
    s_axis_tvalid = 1'b0;
    tick();
    chk("reload_loaded_clr", weights_loaded, 0);
    chk("reload_tready_up", s_axis_tready, 1);

    load_w(64, 1);
    chk("reloaded", weights_loaded, 1);
    send_row(8);
    tick();
    chk("row8_inflight", inflight, 1);

    res_fire = 1'b1;
    tick();
    chk("last_retire", inflight, 0);
    chk("no_err_yet", err_underflow, 0);
    tick();
    res_fire = 1'b0;
    chk("underflow_err", err_underflow, 1);
    chk("underflow_stay0", inflight, 0);
    tick();
    chk("underflow_sticky", err_underflow, 1);

    cfg_reload = 1'b1;
    tick();
    cfg_reload = 1'b0;
    tick();
    tick();
    chk("back_to_load", weights_loaded, 0);
    load_w(10, 2);
    rstn = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();

    load_w(64, 0);
    chk("post_reset_loaded", weights_loaded, 1);
    send_row(9);
    tick();
    chk("post_reset_inflight", inflight, 1);
    repeat (3) tick();
    chk("wt_queue_empty", wq.size(), 0);
    chk("row_queue_empty", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
